// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - streams 32-bit words into a byte-wide instruction store, big-endian (optional checksum: IMLOAD_CHECKSUM_EN)
module instr_mem_loader #(
  parameter int DEPTH = 128
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [31:0] base_addr_i,
  input  logic [5:0]  word_count_i,
  input  logic        in_valid_i,
  input  logic [31:0] in_data_i,
  output logic        in_ready_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [7:0]  mem_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] checksum_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_WR0,
    S_WR1,
    S_WR2,
    S_WR3,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q;
  logic [31:0] ptr_q;
  logic [5:0]  rem_q;
  logic [31:0] word_q;

  // 33-bit end address so a base near the top of the address space cannot wrap past the check
  logic [32:0] end_addr;
  logic        start_bad;
  logic        start_seen;
  logic        start_go;

  assign end_addr   = {1'b0, base_addr_i} + {25'd0, word_count_i, 2'b00};
  assign start_bad  = (base_addr_i[1:0] != 2'b00) || (end_addr > 33'(DEPTH));
  assign start_seen = start_i && ((state_q == S_IDLE) || (state_q == S_ERR));
  assign start_go   = start_seen && !start_bad && (word_count_i != 6'd0);

  // Session sequencer: one WAIT for the handshake, then four byte-write cycles per word
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      ptr_q   <= 32'd0;
      rem_q   <= 6'd0;
      word_q  <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE, S_ERR: begin
          if (start_i) begin
            if (start_bad) begin
              state_q <= S_ERR;
            end else if (word_count_i == 6'd0) begin
              state_q <= S_DONE;
            end else begin
              ptr_q   <= base_addr_i;
              rem_q   <= word_count_i;
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (in_valid_i) begin
            word_q  <= in_data_i;
            state_q <= S_WR0;
          end
        end
        S_WR0: state_q <= S_WR1;
        S_WR1: state_q <= S_WR2;
        S_WR2: state_q <= S_WR3;
        S_WR3: begin
          ptr_q   <= ptr_q + 32'd4;
          rem_q   <= rem_q - 6'd1;
          state_q <= (rem_q == 6'd1) ? S_DONE : S_WAIT;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef IMLOAD_CHECKSUM_EN
  logic [31:0] checksum_q;

  // Word sum: cleared when a session is accepted, accumulated as each word's last byte goes out
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      checksum_q <= 32'd0;
    end else if (start_go) begin
      checksum_q <= 32'd0;
    end else if (state_q == S_WR3) begin
      checksum_q <= checksum_q + word_q;
    end
  end

  assign checksum_o = checksum_q;
`else
  assign checksum_o = 32'd0;
`endif

  // Status and memory-port outputs decoded straight from the state register
  always_comb begin
    in_ready_o = (state_q == S_WAIT);
    busy_o     = (state_q != S_IDLE) && (state_q != S_ERR);
    done_o     = (state_q == S_DONE);
    err_o      = (state_q == S_ERR);
    mem_we_o   = 1'b0;
    mem_addr_o = 32'd0;
    mem_data_o = 8'd0;
    case (state_q)
      S_WR0: begin
        mem_we_o   = 1'b1;
        mem_addr_o = ptr_q;
        mem_data_o = word_q[31:24];
      end
      S_WR1: begin
        mem_we_o   = 1'b1;
        mem_addr_o = ptr_q + 32'd1;
        mem_data_o = word_q[23:16];
      end
      S_WR2: begin
        mem_we_o   = 1'b1;
        mem_addr_o = ptr_q + 32'd2;
        mem_data_o = word_q[15:8];
      end
      S_WR3: begin
        mem_we_o   = 1'b1;
        mem_addr_o = ptr_q + 32'd3;
        mem_data_o = word_q[7:0];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - scoreboard bench for instr_mem_loader with randomized sessions
module tb_instr_mem_loader;

  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [5:0]  word_count;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] checksum;

  instr_mem_loader #(.DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .start_i      (start),
    .base_addr_i  (base_addr),
    .word_count_i (word_count),
    .in_valid_i   (in_valid),
    .in_data_i    (in_data),
    .in_ready_o   (in_ready),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_data_o   (mem_data),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .checksum_o   (checksum)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [39:0] exp_q[$];
  logic [31:0] wbuf[64];
  logic [31:0] cs_exp = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every byte write must match the next expected (addr, data)
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {24'd0, mem_addr, mem_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        chk("write_addr", mem_addr, e[39:8]);
        chk("write_data", mem_data, e[7:0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit start_rejected(input logic [31:0] b, input int cnt);
    longint unsigned last;
    last = longint'(b) + longint'(cnt) * 4;
    return (b % 4 != 0) || (last > DEPTH);
  endfunction

  // Pulse Start and check the immediate outcome; returns 1 when a word phase follows
  task automatic do_start(input logic [31:0] b, input int cnt, output bit go);
    bit bad;
    bad = start_rejected(b, cnt);
    base_addr  = b;
    word_count = 6'(cnt);
    start      = 1'b1;
    step();
    start = 1'b0;
    go = 1'b0;
    if (bad) begin
      chk("err_after_bad_start", err, 1);
      chk("busy_in_err", busy, 0);
      chk("ready_in_err", in_ready, 0);
    end else if (cnt == 0) begin
      chk("zero_done_pulse", done, 1);
      chk("zero_err", err, 0);
      step();
      chk("zero_done_clear", done, 0);
      chk("zero_busy_clear", busy, 0);
    end else begin
      chk("start_busy", busy, 1);
      chk("start_ready", in_ready, 1);
      chk("start_err_clear", err, 0);
      cs_exp = 32'd0;
      go = 1'b1;
    end
  endtask

  task automatic wait_hs(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (in_ready === 1'b1) begin
        step();
        ok = 1'b1;
        return;
      end
      step();
    end
    chk("handshake_timeout", 1, 0);
  endtask

  task automatic push_word(input logic [31:0] a, input logic [31:0] w);
    exp_q.push_back({a,       w[31:24]});
    exp_q.push_back({a + 32'd1, w[23:16]});
    exp_q.push_back({a + 32'd2, w[15:8]});
    exp_q.push_back({a + 32'd3, w[7:0]});
  endtask

  // Full session: words from wbuf, optional idle gap between words, optional held-high valid
  task automatic run_session(input logic [31:0] b, input int cnt, input int gap, input bit hold, input bit poke);
    bit go;
    bit ok;
    logic [31:0] ptr;
    int last_hs;
    do_start(b, cnt, go);
    if (!go) return;
    ptr = b;
    last_hs = 0;
    for (int i = 0; i < cnt; i++) begin
      if (poke && i == 0) begin
        base_addr = 32'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_start_ignored_err", err, 0);
        chk("busy_start_ignored_busy", busy, 1);
        chk("busy_start_ignored_ready", in_ready, 1);
      end
      in_data  = wbuf[i];
      in_valid = 1'b1;
      wait_hs(ok);
      if (!ok) begin
        in_valid = 1'b0;
        return;
      end
      push_word(ptr, wbuf[i]);
`ifdef IMLOAD_CHECKSUM_EN
      cs_exp = cs_exp + wbuf[i];
`endif
      if (hold && i > 0) chk("word_spacing", cyc - last_hs, 5);
      last_hs = cyc;
      if (!hold) in_valid = 1'b0;
      chk("wr0_ready_low", in_ready, 0);
      chk("wr0_we", mem_we, 1);
      if (poke && i == 0) begin
        base_addr = 32'd3;
        start = 1'b1;
      end
      step();
      start = 1'b0;
      step();
      step();
      step();
      ptr = ptr + 32'd4;
      if (i == cnt - 1) begin
        in_valid = 1'b0;
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        step();
        chk("done_clear", done, 0);
        chk("idle_busy", busy, 0);
        chk("checksum", checksum, cs_exp);
      end else begin
        chk("ready_return", in_ready, 1);
        chk("mid_done", done, 0);
        for (int g = 0; g < gap; g++) step();
      end
    end
  endtask

  initial begin
    bit go;
    bit ok;
    reset = 1'b1; start = 1'b0; base_addr = 32'd0; word_count = 6'd0;
    in_valid = 1'b0; in_data = 32'd0;
    step(); step(); step();
    chk("rst_ready", in_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_checksum", checksum, 0);
    reset = 1'b0;
    step();

    wbuf[0] = 32'h8C01_0004; wbuf[1] = 32'h0022_1820;
    run_session(32'd0, 2, 0, 1'b0, 1'b0);
`ifdef IMLOAD_CHECKSUM_EN
    chk("checksum_plan", checksum, 32'h8C23_1824);
`else
    chk("checksum_plan", checksum, 32'h0);
`endif

    run_session(32'd2, 1, 0, 1'b0, 1'b0);
    step(); step();
    chk("err_held", err, 1);
    run_session(32'd120, 3, 0, 1'b0, 1'b0);
    run_session(32'hFFFF_FFFC, 1, 0, 1'b0, 1'b0);
    wbuf[0] = 32'hAABB_CCDD;
    run_session(32'd124, 1, 0, 1'b0, 1'b0);
    chk("err_cleared", err, 0);

    for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
    run_session(32'd16, 3, 3, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) wbuf[i] = 32'h1234_5678;
    run_session(32'd40, 4, 0, 1'b1, 1'b0);
    step(); step();

    do_start(32'd0, 2, go);
    in_data = 32'hDEAD_BEEF;
    in_valid = 1'b1;
    wait_hs(ok);
    in_valid = 1'b0;
    push_word(32'd0, 32'hDEAD_BEEF);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_we", mem_we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_remaining_bytes", exp_q.size(), 2);
    exp_q.delete();
    cs_exp = 32'd0;
    wbuf[0] = 32'h0102_0304; wbuf[1] = 32'hF0E0_D0C0;
    run_session(32'd0, 2, 1, 1'b0, 1'b0);

    run_session(32'd8, 0, 0, 1'b0, 1'b0);

    wbuf[0] = 32'h5555_AAAA; wbuf[1] = 32'h0F0F_F0F0;
    run_session(32'd64, 2, 0, 1'b0, 1'b1);

    for (int s = 0; s < 25; s++) begin
      logic [31:0] b;
      int cnt;
      b   = $urandom_range(0, 140);
      cnt = $urandom_range(0, 12);
      for (int i = 0; i < cnt; i++) wbuf[i] = $urandom;
      run_session(b, cnt, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
      step();
    end

    step(); step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
